// File: rtl/lcd_data_format_adapter_ram_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_data_format_adapter_ram_arbiter
//
// Purpose:
//    Shares one dual-port RAM (independent write and read ports) between two
//    Avalon-MM style requesters, A and B. The write port and the read port are
//    arbitrated independently every cycle, so a write from one requester and a
//    read from the other are both granted in the same cycle. Read results
//    return two cycles after acceptance through a small valid/owner pipeline.
//
// Configuration:
//    LCD_RAM_ARB_ROUND_ROBIN_EN - when defined, each RAM port keeps a
//    "last granted" pointer and a conflict goes to the requester that was not
//    granted last. When undefined, requester A always wins a conflict and no
//    pointer state exists.
//
// Parameters:
//    DATA_WIDTH     - data width of the RAM and both requesters
//    ADDRESS_WIDTH  - address width of the RAM and both requesters
//
// Ports:
//    clk, reset                         - clock, synchronous active-high reset
//    a_address/a_writedata              - requester A command address / data
//    a_write/a_read                     - requester A command strobes
//    a_waitrequest                      - A command not accepted this cycle
//    a_readdata/a_readdatavalid         - A read return data and qualifier
//    b_*                                - same set for requester B
//    ram_wr_address/writedata/write     - shared RAM write port
//    ram_wr_waitrequest                 - RAM write port busy (memory clear)
//    ram_rd_address                     - shared RAM read address
//    ram_rd_readdata                    - RAM read data, 2 cycles after address
// -----------------------------------------------------------------------------
module lcd_data_format_adapter_ram_arbiter #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,

   input  logic [ADDRESS_WIDTH-1:0] a_address,
   input  logic [DATA_WIDTH-1:0]    a_writedata,
   input  logic                     a_write,
   input  logic                     a_read,
   output logic                     a_waitrequest,
   output logic [DATA_WIDTH-1:0]    a_readdata,
   output logic                     a_readdatavalid,

   input  logic [ADDRESS_WIDTH-1:0] b_address,
   input  logic [DATA_WIDTH-1:0]    b_writedata,
   input  logic                     b_write,
   input  logic                     b_read,
   output logic                     b_waitrequest,
   output logic [DATA_WIDTH-1:0]    b_readdata,
   output logic                     b_readdatavalid,

   output logic [ADDRESS_WIDTH-1:0] ram_wr_address,
   output logic [DATA_WIDTH-1:0]    ram_wr_writedata,
   output logic                     ram_wr_write,
   input  logic                     ram_wr_waitrequest,

   output logic [ADDRESS_WIDTH-1:0] ram_rd_address,
   input  logic [DATA_WIDTH-1:0]    ram_rd_readdata
);

   // Grant decisions for the current cycle
   logic                     w_wr_gnt_a;
   logic                     w_wr_gnt_b;
   logic                     w_rd_gnt_a;
   logic                     w_rd_gnt_b;
   logic [ADDRESS_WIDTH-1:0] w_rd_address;

   // Last accepted read address, presented while the read port is idle
   logic [ADDRESS_WIDTH-1:0] r_rd_address;

   // Read return pipeline: stage 1 = accepted last edge, stage 2 = data now
   logic                     r_s1_valid;
   logic                     r_s1_owner_b;
   logic                     r_s2_valid;
   logic                     r_s2_owner_b;

`ifdef LCD_RAM_ARB_ROUND_ROBIN_EN
   // 1 = requester B was granted last on that port
   logic                     r_wr_last_b;
   logic                     r_rd_last_b;
`endif

   // Write port arbitration; a busy RAM write port (memory clear) blocks both
   always_comb begin
      w_wr_gnt_a = 1'b0;
      w_wr_gnt_b = 1'b0;
      if (reset || ram_wr_waitrequest) begin
         w_wr_gnt_a = 1'b0;
         w_wr_gnt_b = 1'b0;
      end else if (a_write && b_write) begin
`ifdef LCD_RAM_ARB_ROUND_ROBIN_EN
         if (r_wr_last_b) begin
            w_wr_gnt_a = 1'b1;
         end else begin
            w_wr_gnt_b = 1'b1;
         end
`else
         w_wr_gnt_a = 1'b1;
`endif
      end else begin
         w_wr_gnt_a = a_write;
         w_wr_gnt_b = b_write;
      end
   end

   // Read port arbitration, independent of the write port
   always_comb begin
      w_rd_gnt_a = 1'b0;
      w_rd_gnt_b = 1'b0;
      if (reset) begin
         w_rd_gnt_a = 1'b0;
         w_rd_gnt_b = 1'b0;
      end else if (a_read && b_read) begin
`ifdef LCD_RAM_ARB_ROUND_ROBIN_EN
         if (r_rd_last_b) begin
            w_rd_gnt_a = 1'b1;
         end else begin
            w_rd_gnt_b = 1'b1;
         end
`else
         w_rd_gnt_a = 1'b1;
`endif
      end else begin
         w_rd_gnt_a = a_read;
         w_rd_gnt_b = b_read;
      end
   end

   // Read address mux; holds the last granted address when the port is idle
   always_comb begin
      w_rd_address = r_rd_address;
      if (w_rd_gnt_a) begin
         w_rd_address = a_address;
      end else if (w_rd_gnt_b) begin
         w_rd_address = b_address;
      end else begin
         w_rd_address = r_rd_address;
      end
   end

   // Waitrequest is combinational so a granted command completes this cycle;
   // during reset both requesters are held off regardless of their strobes.
   assign a_waitrequest = reset | (a_write & ~w_wr_gnt_a) | (a_read & ~w_rd_gnt_a);
   assign b_waitrequest = reset | (b_write & ~w_wr_gnt_b) | (b_read & ~w_rd_gnt_b);

   assign ram_wr_write     = w_wr_gnt_a | w_wr_gnt_b;
   assign ram_wr_address   = w_wr_gnt_b ? b_address   : a_address;
   assign ram_wr_writedata = w_wr_gnt_b ? b_writedata : a_writedata;
   assign ram_rd_address   = w_rd_address;

   // RAM read data is broadcast; only the owner's valid marks it as its result
   assign a_readdata      = ram_rd_readdata;
   assign b_readdata      = ram_rd_readdata;
   assign a_readdatavalid = r_s2_valid & ~r_s2_owner_b & ~reset;
   assign b_readdatavalid = r_s2_valid &  r_s2_owner_b & ~reset;

   // Read address hold register and two-stage read return pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_address <= {ADDRESS_WIDTH{1'b0}};
         r_s1_valid   <= 1'b0;
         r_s1_owner_b <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_s2_owner_b <= 1'b0;
      end else begin
         r_rd_address <= w_rd_address;
         r_s1_valid   <= w_rd_gnt_a | w_rd_gnt_b;
         r_s1_owner_b <= w_rd_gnt_b;
         r_s2_valid   <= r_s1_valid;
         r_s2_owner_b <= r_s1_owner_b;
      end
   end

`ifdef LCD_RAM_ARB_ROUND_ROBIN_EN
   // Last-granted pointers; reset leaves B as last granted so A wins first
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_last_b <= 1'b1;
         r_rd_last_b <= 1'b1;
      end else begin
         if (w_wr_gnt_a || w_wr_gnt_b) begin
            r_wr_last_b <= w_wr_gnt_b;
         end else begin
            r_wr_last_b <= r_wr_last_b;
         end
         if (w_rd_gnt_a || w_rd_gnt_b) begin
            r_rd_last_b <= w_rd_gnt_b;
         end else begin
            r_rd_last_b <= r_rd_last_b;
         end
      end
   end
`endif

endmodule

// File: doc/lcd_data_format_adapter_ram_arbiter.md
LCD_DATA_FORMAT_ADAPTER_RAM_ARBITER -- requirements
Module: lcd_data_format_adapter_ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bus width of the shared RAM and both requesters.
REQ-002 Parameter ADDRESS_WIDTH, default 4, address width of the shared RAM and both requesters.
REQ-003 Ports clk and reset SHALL be provided: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 a_address  in  ADDRESS_WIDTH  requester A command address.
REQ-007 a_writedata  in  DATA_WIDTH  requester A write data.
REQ-008 a_write / a_read  in  1 each  requester A command strobes; never both high in one cycle.
REQ-009 a_waitrequest  out  1  requester A command not accepted this cycle.
REQ-010 a_readdata  out  DATA_WIDTH  read data, qualified by a_readdatavalid.
REQ-011 a_readdatavalid  out  1  a_readdata carries the result of an accepted requester A read.
REQ-012 Ports b_* SHALL mirror REQ-006..REQ-011 for requester B.
REQ-013 ram_wr_address / ram_wr_writedata / ram_wr_write  out  ADDRESS_WIDTH / DATA_WIDTH / 1  shared RAM write port.
REQ-014 ram_wr_waitrequest  in  1  RAM write port busy (memory clear in progress).
REQ-015 ram_rd_address  out  ADDRESS_WIDTH  shared RAM read address.
REQ-016 ram_rd_readdata  in  DATA_WIDTH  RAM read data, valid 2 cycles after the address.

Function
REQ-017 Write port and read port SHALL be arbitrated independently each cycle: a write from one requester and a read from the other are both granted in the same cycle.
REQ-018 Write conflict (a_write and b_write): exactly one granted per the write priority rule (REQ-033/034); loser waitrequest=1.
REQ-019 Read conflict (a_read and b_read): exactly one granted per the read priority rule; loser waitrequest=1.
REQ-020 ram_wr_waitrequest=1: no write granted, ram_wr_write=0, waitrequest=1 for every requester asserting write; reads unaffected.
REQ-021 x_waitrequest = (x_write or x_read) and not granted, combinational in the same cycle; 0 when idle.
REQ-022 Granted write: ram_wr_write=1, ram_wr_address/writedata from the granter in the same cycle; otherwise ram_wr_write=0.
REQ-023 Granted read: ram_rd_address = granter address in the same cycle; with no read granted, ram_rd_address holds its last value.
REQ-024 Read tracking: 2-stage valid/owner pipeline; read accepted on edge n -> x_readdatavalid=1 for exactly one cycle, in the cycle after edge n+1 (data of cycle n+2).
REQ-025 a_readdata and b_readdata SHALL both carry ram_rd_readdata; only the owner's readdatavalid is asserted.
REQ-026 Back-to-back reads SHALL be sustained at one per cycle, per-owner order preserved; at most 2 reads in flight.
REQ-027 Write-then-read same address: no arbiter-side ordering logic; the RAM lookahead returns the new data.

Reset
REQ-028 While reset=1: a_waitrequest=b_waitrequest=1, ram_wr_write=0, a_readdatavalid=b_readdatavalid=0.
REQ-029 Reset edge SHALL clear the read pipeline; reads in flight are discarded, no readdatavalid for them.
REQ-030 Reset edge SHALL set both round-robin pointers to "B last granted".
REQ-031 ram_rd_address SHALL reset to 0.
REQ-032 First cycle after reset deasserts: arbiter fully operational.

Configuration
REQ-033 Macro LCD_RAM_ARB_ROUND_ROBIN_EN defined: each port keeps a last-granted pointer; on conflict the requester not last granted wins; pointer updates on every grant of that port.
REQ-034 Macro undefined: fixed priority, A always wins conflicts on both ports; no pointer state.

Verification
REQ-035 Reset held 3 cycles, a_write=1 -> a_waitrequest=1, ram_wr_write=0 throughout; ram_wr_write=1 first cycle after release.
REQ-036 a_write addr 3 data 0x5A and b_read addr 7 same cycle -> both waitrequest=0; ram_wr_write=1; b_readdatavalid exactly 2 cycles later with RAM data of addr 7.
REQ-037 a_read and b_read held 4 cycles, round-robin build -> grants A,B,A,B; readdatavalid A,B,A,B at cycles +2..+5; fixed-priority build -> A 4 times, b_waitrequest=1 throughout.
REQ-038 ram_wr_waitrequest=1 for 5 cycles with b_write=1 and a_read=1 -> b_waitrequest=1 all 5 cycles, ram_wr_write=0, a_read accepted every cycle.
REQ-039 Write addr 2 data 0x11 then read addr 2 next cycle -> readdatavalid with data 0x11.
REQ-040 Reset asserted one cycle after a read acceptance -> no readdatavalid for that read; pointers restored to REQ-030.
